// File: rtl/rv_fetch_pkg.sv
// Shared types for the instruction fetch sequencer.
// Holds the FSM state enum and the PC increments in halfwords.
package rv_fetch_pkg;

  typedef enum logic [1:0] {
    S_FLUSH   = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_t;

  localparam int unsigned FETCH_WORD_HW = 2;
  localparam int unsigned FETCH_HALF_HW = 1;

endpackage

// File: rtl/rv_fetch_ctrl_if.sv
// Fetch controller bundle: redirect in, buffer push/flush side, imem port.
// master = fetch controller, slave = core/buffer/bus environment.
interface rv_fetch_ctrl_if #(
  parameter int IADDR_SPACE_BITS = 16
);
  localparam int PW = IADDR_SPACE_BITS - 1;

  logic          i_redirect;
  logic [PW-1:0] i_redirect_pc;
  logic          i_buf_full;
  logic          o_buf_flush;
  logic [PW-1:0] o_buf_pc;
  logic          o_push_single;
  logic          o_push_double;
  logic [15:0]   o_data_lo;
  logic [15:0]   o_data_hi;
  logic          o_imem_req;
  logic [PW-2:0] o_imem_addr;
  logic          i_imem_ack;
  logic [31:0]   i_imem_data;

  modport master (
    input  i_redirect, i_redirect_pc, i_buf_full,
    input  i_imem_ack, i_imem_data,
    output o_buf_flush, o_buf_pc,
    output o_push_single, o_push_double,
    output o_data_lo, o_data_hi,
    output o_imem_req, o_imem_addr
  );

  modport slave (
    output i_redirect, i_redirect_pc, i_buf_full,
    output i_imem_ack, i_imem_data,
    input  o_buf_flush, o_buf_pc,
    input  o_push_single, o_push_double,
    input  o_data_lo, o_data_hi,
    input  o_imem_req, o_imem_addr
  );

endinterface

// File: rtl/rv_fetch_ctrl_add.sv
// Plain modulo adder used for the fetch PC increment.
// Ports: a_i, b_i operands; sum_o = a_i + b_i, wrapping at WIDTH bits.
module add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/rv_fetch_ctrl.sv
// Fetch sequencer: issues imem word reads, pushes halfwords to the buffer.
// Ports: i_clk, i_reset (sync, active-high), bus (redirect/buffer/imem).
module rv_fetch_ctrl
  import rv_fetch_pkg::*;
#(
  parameter int IADDR_SPACE_BITS = 16,
  parameter logic [IADDR_SPACE_BITS-2:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  rv_fetch_ctrl_if.master bus
);

  localparam int PW = IADDR_SPACE_BITS - 1;

  fetch_state_t  state_q, state_d;
  logic [PW-1:0] pc_q, pc_d, pc_inc, inc;
  logic [PW-2:0] addr_q, addr_d, addr;
  logic          issued_q, issued_d;
  logic          flush_q;
  logic          ps_q, ps_d, pd_q, pd_d;
  logic [15:0]   lo_q, lo_d, hi_q, hi_d;
  logic          req, pend;

  // pc_q[0] is byte-address bit 1: set means misaligned.
  assign inc = pc_q[0] ? PW'(FETCH_HALF_HW)
                       : PW'(FETCH_WORD_HW);

  add #(.WIDTH(PW)) u_add (
    .a_i   (pc_q),
    .b_i   (inc),
    .sum_o (pc_inc)
  );

  assign pend = ps_q | pd_q;

  // An issued request keeps its latched address until acked.
  assign addr = issued_q ? addr_q : pc_q[PW-1:1];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    ps_d     = 1'b0;
    pd_d     = 1'b0;
    lo_d     = lo_q;
    hi_d     = hi_q;
    req      = 1'b0;
    unique case (state_q)
      S_FLUSH: state_d = S_REQ;
      S_REQ: begin
        req = issued_q
            | (!bus.i_buf_full & !pend);
        if (req && bus.i_imem_ack) begin
          pc_d = pc_inc;
          hi_d = bus.i_imem_data[31:16];
          if (pc_q[0]) begin
            ps_d = 1'b1;
          end else begin
            pd_d = 1'b1;
            lo_d = bus.i_imem_data[15:0];
          end
        end
      end
      S_DISCARD: begin
        req = 1'b1;
        if (bus.i_imem_ack) state_d = S_REQ;
      end
      default: state_d = S_FLUSH;
    endcase
    issued_d = req & !bus.i_imem_ack;
    if (issued_d) addr_d = addr;
    if (bus.i_redirect) begin
      pc_d    = bus.i_redirect_pc;
      ps_d    = 1'b0;
      pd_d    = 1'b0;
      state_d = issued_d ? S_DISCARD : S_FLUSH;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_FLUSH;
      pc_q     <= RESET_PC;
      addr_q   <= '0;
      issued_q <= 1'b0;
      flush_q  <= 1'b1;
      ps_q     <= 1'b0;
      pd_q     <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      issued_q <= issued_d;
      flush_q  <= bus.i_redirect;
      ps_q     <= ps_d;
      pd_q     <= pd_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  end

  assign bus.o_buf_flush   = flush_q;
  assign bus.o_buf_pc      = pc_q;
  assign bus.o_imem_req    = req & !i_reset;
  assign bus.o_imem_addr   = addr;
  assign bus.o_push_single = ps_q & !i_reset;
  assign bus.o_push_double = pd_q & !i_reset;
  assign bus.o_data_lo     = i_reset ? 16'h0 : lo_q;
  assign bus.o_data_hi     = i_reset ? 16'h0 : hi_q;

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// Directed bench for rv_fetch_ctrl: reset, pushes, full, redirects, wrap.
// Inputs change 1ns after posedge; outputs are checked 2ns after posedge.
module tb_rv_fetch_ctrl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  rv_fetch_ctrl_if #(.IADDR_SPACE_BITS(16)) bus ();

  rv_fetch_ctrl #(
    .IADDR_SPACE_BITS (16),
    .RESET_PC         (15'h40)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    #0;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic redir,
                       input logic [14:0] rpc,
                       input logic ack,
                       input logic [31:0] data);
    bus.i_redirect    = redir;
    bus.i_redirect_pc = rpc;
    bus.i_imem_ack    = ack;
    bus.i_imem_data   = data;
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.i_buf_full = 1'b0;
    drive(1'b0, 15'h0, 1'b0, 32'h0);
    tick();
    tick();
    #1;
    chk("rst_flush", 32'(bus.o_buf_flush), 1);
    chk("rst_pc", 32'(bus.o_buf_pc), 32'h40);
    chk("rst_req", 32'(bus.o_imem_req), 0);
    chk("rst_push", 32'({bus.o_push_single,
                         bus.o_push_double}), 0);
    rst = 1'b0;
    #1;
    // first cycle after reset: flush cycle
    chk("t1_flush", 32'(bus.o_buf_flush), 1);
    chk("t1_flpc", 32'(bus.o_buf_pc), 32'h40);
    chk("t1_req0", 32'(bus.o_imem_req), 0);
    chk("t1_data0", {bus.o_data_hi, bus.o_data_lo}, 0);
    tick();
    drive(1'b0, 15'h0, 1'b1, 32'h1111_0000);
    chk("t1_req_a", 32'(bus.o_imem_req), 1);
    chk("t1_addr_a", 32'(bus.o_imem_addr), 32'h20);
    chk("t1_flush0", 32'(bus.o_buf_flush), 0);
    tick();
    drive(1'b0, 15'h0, 1'b0, 32'h0);
    chk("t1_pd_a", 32'(bus.o_push_double), 1);
    chk("t1_dat_a", {bus.o_data_hi, bus.o_data_lo},
        32'h1111_0000);
    chk("t1_hold", 32'(bus.o_imem_req), 0);
    tick();
    drive(1'b0, 15'h0, 1'b1, 32'h2222_3333);
    chk("t1_pd_off", 32'(bus.o_push_double), 0);
    chk("t1_addr_b", 32'(bus.o_imem_addr), 32'h21);
    tick();
    drive(1'b0, 15'h0, 1'b0, 32'h0);
    chk("t1_dat_b", {bus.o_data_hi, bus.o_data_lo},
        32'h2222_3333);
    tick();
    drive(1'b0, 15'h0, 1'b1, 32'h4444_5555);
    chk("t1_addr_c", 32'(bus.o_imem_addr), 32'h22);
    tick();
    // t2: redirect to misaligned 'h13
    drive(1'b1, 15'h13, 1'b0, 32'h0);
    chk("t1_pd_c", 32'(bus.o_push_double), 1);
    tick();
    drive(1'b0, 15'h0, 1'b0, 32'h0);
    chk("t2_flush", 32'(bus.o_buf_flush), 1);
    chk("t2_flpc", 32'(bus.o_buf_pc), 32'h13);
    chk("t2_req0", 32'(bus.o_imem_req), 0);
    tick();
    drive(1'b0, 15'h0, 1'b1, 32'hAAAA_BBBB);
    chk("t2_addr", 32'(bus.o_imem_addr), 32'h09);
    tick();
    drive(1'b0, 15'h0, 1'b0, 32'h0);
    chk("t2_ps", 32'(bus.o_push_single), 1);
    chk("t2_pd0", 32'(bus.o_push_double), 0);
    chk("t2_hi", 32'(bus.o_data_hi), 32'hAAAA);
    tick();
    drive(1'b0, 15'h0, 1'b1, 32'h1234_5678);
    chk("t2_addr2", 32'(bus.o_imem_addr), 32'h0A);
    tick();
    drive(1'b0, 15'h0, 1'b0, 32'h0);
    chk("t2_pd", 32'(bus.o_push_double), 1);
    chk("t2_dat", {bus.o_data_hi, bus.o_data_lo},
        32'h1234_5678);
    tick();
    // t3: buffer full for 5 cycles
    bus.i_buf_full = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_req_lo", 32'(bus.o_imem_req), 0);
      chk("t3_nopush", 32'({bus.o_push_single,
                            bus.o_push_double}), 0);
      tick();
    end
    bus.i_buf_full = 1'b0;
    #1;
    chk("t3_req_up", 32'(bus.o_imem_req), 1);
    chk("t3_addr", 32'(bus.o_imem_addr), 32'h0B);
    tick();
    // t4: redirect while request outstanding
    drive(1'b1, 15'h80, 1'b0, 32'h0);
    chk("t4_req", 32'(bus.o_imem_req), 1);
    tick();
    drive(1'b0, 15'h0, 1'b0, 32'h0);
    chk("t4_flush", 32'(bus.o_buf_flush), 1);
    chk("t4_flpc", 32'(bus.o_buf_pc), 32'h80);
    chk("t4_hold1", 32'(bus.o_imem_addr), 32'h0B);
    tick();
    chk("t4_flush0", 32'(bus.o_buf_flush), 0);
    chk("t4_hold2", 32'(bus.o_imem_addr), 32'h0B);
    chk("t4_req2", 32'(bus.o_imem_req), 1);
    tick();
    drive(1'b0, 15'h0, 1'b1, 32'hDEAD_BEEF);
    chk("t4_hold3", 32'(bus.o_imem_addr), 32'h0B);
    tick();
    drive(1'b0, 15'h0, 1'b0, 32'h0);
    chk("t4_drop", 32'({bus.o_push_single,
                        bus.o_push_double}), 0);
    chk("t4_nreq", 32'(bus.o_imem_req), 1);
    chk("t4_naddr", 32'(bus.o_imem_addr), 32'h40);
    // t5: redirect in the same cycle as ack
    drive(1'b1, 15'h100, 1'b1, 32'hCAFE_F00D);
    tick();
    drive(1'b0, 15'h0, 1'b0, 32'h0);
    chk("t5_nopush", 32'({bus.o_push_single,
                          bus.o_push_double}), 0);
    chk("t5_flush", 32'(bus.o_buf_flush), 1);
    chk("t5_flpc", 32'(bus.o_buf_pc), 32'h100);
    tick();
    chk("t5_req", 32'(bus.o_imem_req), 1);
    chk("t5_addr", 32'(bus.o_imem_addr), 32'h80);
    // t6: reset mid S_DISCARD
    drive(1'b1, 15'h7FFE, 1'b0, 32'h0);
    tick();
    drive(1'b0, 15'h0, 1'b0, 32'h0);
    chk("t6_disc", 32'(bus.o_imem_addr), 32'h80);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_rflush", 32'(bus.o_buf_flush), 1);
    chk("t6_rpc", 32'(bus.o_buf_pc), 32'h40);
    chk("t6_rreq", 32'(bus.o_imem_req), 0);
    tick();
    chk("t6_raddr", 32'(bus.o_imem_addr), 32'h20);
    // wrap: 'h7FFE + 2 -> 0
    drive(1'b1, 15'h7FFE, 1'b1, 32'h9999_9999);
    tick();
    drive(1'b0, 15'h0, 1'b0, 32'h0);
    chk("t6_wflpc", 32'(bus.o_buf_pc), 32'h7FFE);
    chk("t6_wdrop", 32'(bus.o_push_double), 0);
    tick();
    drive(1'b0, 15'h0, 1'b1, 32'h1111_2222);
    chk("t6_waddr", 32'(bus.o_imem_addr), 32'h3FFF);
    tick();
    drive(1'b0, 15'h0, 1'b0, 32'h0);
    chk("t6_wpd", 32'(bus.o_push_double), 1);
    chk("t6_wpc", 32'(bus.o_buf_pc), 32'h0);
    tick();
    chk("t6_waddr0", 32'(bus.o_imem_addr), 32'h0);
    chk("t6_wreq", 32'(bus.o_imem_req), 1);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
